// File: rtl/clock_set_controller.sv
// Edit sequencer for the h:m:s counter: freeze, edit hour/minute, one-cycle load.
// Optional alarm fields and alarm_fire pulse under `define CLOCK_ALARM_EN.
module clock_set_controller #(
    parameter int TIMEOUT_S  = 30,
    parameter int REPEAT_DLY = 8,
    parameter int REPEAT_PER = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_minute,
    output logic       count_en,
    output logic       load,
    output logic [4:0] load_hour,
    output logic [5:0] load_minute,
    output logic [5:0] load_second,
    output logic       blink_hour,
    output logic       blink_minute,
    output logic       editing,
    output logic       alarm_fire
);

    localparam int IW = $clog2(TIMEOUT_S + 1);

    typedef enum logic [2:0] {
        RUN         = 3'd0,
        SET_HOUR    = 3'd1,
        SET_MIN     = 3'd2,
`ifdef CLOCK_ALARM_EN
        SET_AL_HOUR = 3'd3,
        SET_AL_MIN  = 3'd4,
`endif
        COMMIT      = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [4:0]    sh_h_q, sh_h_d;
    logic [5:0]    sh_m_q, sh_m_d;
    logic          inc_prev_q;
    logic [7:0]    rep_q, rep_d;
    logic          rpt_q, rpt_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          phase_q, phase_d;

    logic          count_en_q;
    logic          load_q;
    logic [4:0]    load_hour_q;
    logic [5:0]    load_minute_q;
    logic          blink_hour_q;
    logic          blink_minute_q;
    logic          editing_q;

    logic inc_edge;
    logic inc_rep;
    logic inc;
    logic edit_st;
    logic activity;
    logic timeout;
    logic hour_fld_d;
    logic min_fld_d;

    function automatic logic [4:0] wrap_h(input logic [4:0] v);
        return (v == 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [5:0] wrap_m(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

`ifdef CLOCK_ALARM_EN
    logic [4:0] al_h_q, al_h_d;
    logic [5:0] al_m_q, al_m_d;
    logic [4:0] ash_h_q, ash_h_d;
    logic [5:0] ash_m_q, ash_m_d;
    logic [5:0] min_prev_q;
    logic       fire_q;
    logic       fire_d;
`endif

    assign inc_edge = btn_inc & ~inc_prev_q;
    assign activity = btn_mode | btn_inc;

    always_comb begin
        edit_st = 1'b0;
        unique case (state_q)
            SET_HOUR,
`ifdef CLOCK_ALARM_EN
            SET_AL_HOUR,
            SET_AL_MIN,
`endif
            SET_MIN: edit_st = 1'b1;
            default: edit_st = 1'b0;
        endcase
    end

    // Auto-repeat: initial delay phase (rpt=0), then periodic phase (rpt=1)
    always_comb begin
        rep_d   = rep_q;
        rpt_d   = rpt_q;
        inc_rep = 1'b0;
        if (!btn_inc || !edit_st || btn_mode) begin
            rep_d = 8'd0;
            rpt_d = 1'b0;
        end else if (inc_edge) begin
            rep_d = 8'd1;
            rpt_d = 1'b0;
        end else if (!rpt_q) begin
            if (rep_q == 8'(REPEAT_DLY)) begin
                inc_rep = 1'b1;
                rpt_d   = 1'b1;
                rep_d   = 8'd1;
            end else begin
                rep_d = rep_q + 8'd1;
            end
        end else begin
            if (rep_q == 8'(REPEAT_PER)) begin
                inc_rep = 1'b1;
                rep_d   = 8'd1;
            end else begin
                rep_d = rep_q + 8'd1;
            end
        end
    end

    assign inc = edit_st & ~btn_mode & (inc_edge | inc_rep);

    assign timeout = edit_st & tick_1hz & ~activity
                   & (idle_q == IW'(TIMEOUT_S - 1));

    always_comb begin
        idle_d = idle_q;
        if (!edit_st || activity) begin
            idle_d = '0;
        end else if (tick_1hz) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_comb begin
        phase_d = phase_q;
        if (activity) begin
            phase_d = 1'b1;
        end else if (tick_1hz) begin
            phase_d = ~phase_q;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_h_d  = sh_h_q;
        sh_m_d  = sh_m_q;
`ifdef CLOCK_ALARM_EN
        al_h_d  = al_h_q;
        al_m_d  = al_m_q;
        ash_h_d = ash_h_q;
        ash_m_d = ash_m_q;
`endif
        unique case (state_q)
            RUN: begin
                if (btn_mode) begin
                    state_d = SET_HOUR;
                    sh_h_d  = cur_hour;
                    sh_m_d  = cur_minute;
`ifdef CLOCK_ALARM_EN
                    ash_h_d = al_h_q;
                    ash_m_d = al_m_q;
`endif
                end
            end
            SET_HOUR: begin
                if (btn_mode) begin
                    state_d = SET_MIN;
                end else if (timeout) begin
                    state_d = RUN;
                end else if (inc) begin
                    sh_h_d = wrap_h(sh_h_q);
                end
            end
            SET_MIN: begin
                if (btn_mode) begin
`ifdef CLOCK_ALARM_EN
                    state_d = SET_AL_HOUR;
`else
                    state_d = COMMIT;
`endif
                end else if (timeout) begin
                    state_d = RUN;
                end else if (inc) begin
                    sh_m_d = wrap_m(sh_m_q);
                end
            end
`ifdef CLOCK_ALARM_EN
            SET_AL_HOUR: begin
                if (btn_mode) begin
                    state_d = SET_AL_MIN;
                end else if (timeout) begin
                    state_d = RUN;
                end else if (inc) begin
                    ash_h_d = wrap_h(ash_h_q);
                end
            end
            SET_AL_MIN: begin
                if (btn_mode) begin
                    state_d = COMMIT;
                    al_h_d  = ash_h_q;
                    al_m_d  = ash_m_q;
                end else if (timeout) begin
                    state_d = RUN;
                end else if (inc) begin
                    ash_m_d = wrap_m(ash_m_q);
                end
            end
`endif
            COMMIT:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        hour_fld_d = (state_d == SET_HOUR);
        min_fld_d  = (state_d == SET_MIN);
`ifdef CLOCK_ALARM_EN
        hour_fld_d = hour_fld_d | (state_d == SET_AL_HOUR);
        min_fld_d  = min_fld_d  | (state_d == SET_AL_MIN);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            sh_h_q         <= '0;
            sh_m_q         <= '0;
            inc_prev_q     <= 1'b0;
            rep_q          <= '0;
            rpt_q          <= 1'b0;
            idle_q         <= '0;
            phase_q        <= 1'b1;
            count_en_q     <= 1'b1;
            load_q         <= 1'b0;
            load_hour_q    <= '0;
            load_minute_q  <= '0;
            blink_hour_q   <= 1'b0;
            blink_minute_q <= 1'b0;
            editing_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            sh_h_q         <= sh_h_d;
            sh_m_q         <= sh_m_d;
            inc_prev_q     <= btn_inc;
            rep_q          <= rep_d;
            rpt_q          <= rpt_d;
            idle_q         <= idle_d;
            phase_q        <= phase_d;
            count_en_q     <= (state_d == RUN);
            load_q         <= (state_d == COMMIT);
            if (state_d == COMMIT) begin
                load_hour_q   <= sh_h_d;
                load_minute_q <= sh_m_d;
            end
            blink_hour_q   <= hour_fld_d & ~phase_d;
            blink_minute_q <= min_fld_d & ~phase_d;
            editing_q      <= (state_d != RUN);
        end
    end

`ifdef CLOCK_ALARM_EN
    // Fire only on the cycle the minute changes onto the alarm time
    assign fire_d = (state_q == RUN)
                  & (cur_minute != min_prev_q)
                  & (cur_hour == al_h_q)
                  & (cur_minute == al_m_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            al_h_q     <= '0;
            al_m_q     <= '0;
            ash_h_q    <= '0;
            ash_m_q    <= '0;
            min_prev_q <= '0;
            fire_q     <= 1'b0;
        end else begin
            al_h_q     <= al_h_d;
            al_m_q     <= al_m_d;
            ash_h_q    <= ash_h_d;
            ash_m_q    <= ash_m_d;
            min_prev_q <= cur_minute;
            fire_q     <= fire_d;
        end
    end

    assign alarm_fire = fire_q;
`else
    assign alarm_fire = 1'b0;
`endif

    assign count_en     = count_en_q;
    assign load         = load_q;
    assign load_hour    = load_hour_q;
    assign load_minute  = load_minute_q;
    assign load_second  = 6'd0;
    assign blink_hour   = blink_hour_q;
    assign blink_minute = blink_minute_q;
    assign editing      = editing_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Scoreboard bench for clock_set_controller: loads are queued when the
// commit press is driven and compared when the load strobe appears.
module tb_clock_set_controller;

    logic       clk;
    logic       rst;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] cur_hour;
    logic [5:0] cur_minute;
    logic       count_en;
    logic       load;
    logic [4:0] load_hour;
    logic [5:0] load_minute;
    logic [5:0] load_second;
    logic       blink_hour;
    logic       blink_minute;
    logic       editing;
    logic       alarm_fire;

    typedef struct {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
    } ld_t;

    ld_t sb[$];
    int  errs;
    int  checks;
    int  load_cnt;
    int  fire_cnt;
    int  n_push;

    clock_set_controller dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .btn_mode    (btn_mode),
        .btn_inc     (btn_inc),
        .cur_hour    (cur_hour),
        .cur_minute  (cur_minute),
        .count_en    (count_en),
        .load        (load),
        .load_hour   (load_hour),
        .load_minute (load_minute),
        .load_second (load_second),
        .blink_hour  (blink_hour),
        .blink_minute(blink_minute),
        .editing     (editing),
        .alarm_fire  (alarm_fire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        ld_t e;
        if (load === 1'b1) begin
            load_cnt++;
            if (sb.size() == 0) begin
                check("load_unexp", 1, 0);
            end else begin
                e = sb.pop_front();
                check("load_h", 32'(load_hour), 32'(e.h));
                check("load_m", 32'(load_minute), 32'(e.m));
                check("load_s", 32'(load_second), 32'(e.s));
            end
        end
        if (alarm_fire === 1'b1) fire_cnt++;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        step(1);
        btn_mode = 1'b0;
    endtask

    task automatic inc_once();
        btn_inc = 1'b1;
        step(1);
        btn_inc = 1'b0;
        step(1);
    endtask

    // From SET_MIN: walk any alarm fields, then the commit press
    task automatic commit_from_min(input logic [4:0] h,
                                   input logic [5:0] m);
        ld_t e;
`ifdef CLOCK_ALARM_EN
        press_mode();
        press_mode();
`endif
        e.h = h;
        e.m = m;
        e.s = 6'd0;
        sb.push_back(e);
        n_push++;
        press_mode();
    endtask

    initial begin
        int lc0;
        int fc0;
        errs       = 0;
        checks     = 0;
        load_cnt   = 0;
        fire_cnt   = 0;
        n_push     = 0;
        rst        = 1'b1;
        tick_1hz   = 1'b0;
        btn_mode   = 1'b0;
        btn_inc    = 1'b0;
        cur_hour   = 5'd12;
        cur_minute = 6'd0;
        step(3);
        rst = 1'b0;
        step(1);
        check("rst_count_en", 32'(count_en), 1);
        check("rst_load", 32'(load), 0);
        check("rst_editing", 32'(editing), 0);
        check("rst_blink_h", 32'(blink_hour), 0);
        check("rst_blink_m", 32'(blink_minute), 0);
        check("rst_load_h", 32'(load_hour), 0);
        check("rst_load_m", 32'(load_minute), 0);
        check("rst_load_s", 32'(load_second), 0);
        check("rst_alarm", 32'(alarm_fire), 0);

        // reset held mid-edit
        press_mode();
        press_mode();
        check("midedit_editing", 32'(editing), 1);
        check("midedit_count_en", 32'(count_en), 0);
        rst = 1'b1;
        step(3);
        check("mrst_editing", 32'(editing), 0);
        check("mrst_count_en", 32'(count_en), 1);
        check("mrst_load", 32'(load), 0);
        rst = 1'b0;
        step(2);
        check("mrst_editing2", 32'(editing), 0);
        check("mrst_count_en2", 32'(count_en), 1);
        check("mrst_blink_m", 32'(blink_minute), 0);
        check("mrst_nolod", 32'(load_cnt), 0);

        // 23:59 wraps to 00:00
        cur_hour   = 5'd23;
        cur_minute = 6'd59;
        step(1);
        press_mode();
        check("wrap_cen_a", 32'(count_en), 0);
        check("wrap_edit", 32'(editing), 1);
        inc_once();
        check("wrap_cen_b", 32'(count_en), 0);
        press_mode();
        inc_once();
        check("wrap_cen_c", 32'(count_en), 0);
        lc0 = load_cnt;
        commit_from_min(5'd0, 6'd0);
        check("wrap_load_on", 32'(load), 1);
        check("wrap_cen_ld", 32'(count_en), 0);
        step(1);
        check("wrap_load_off", 32'(load), 0);
        check("wrap_cen_run", 32'(count_en), 1);
        check("wrap_edit_off", 32'(editing), 0);
        check("wrap_one_load", 32'(load_cnt - lc0), 1);

        // auto-repeat: 10 -> 14 over 20 held cycles
        cur_hour   = 5'd5;
        cur_minute = 6'd10;
        step(1);
        press_mode();
        press_mode();
        check("rep_blink_m", 32'(blink_minute), 0);
        btn_inc = 1'b1;
        step(8 + 3 * 4);
        btn_inc = 1'b0;
        step(1);
        commit_from_min(5'd5, 6'd14);
        step(2);

        // idle timeout after 30 ticks, blink toggling meanwhile
        cur_hour   = 5'd9;
        cur_minute = 6'd15;
        step(1);
        press_mode();
        check("to_blink0", 32'(blink_hour), 0);
        lc0 = load_cnt;
        for (int k = 1; k <= 30; k++) begin
            tick_1hz = 1'b1;
            step(1);
            tick_1hz = 1'b0;
            if (k < 30) begin
                check($sformatf("to_blink_%0d", k),
                      32'(blink_hour), 32'(k % 2));
                if (k == 29) check("to_edit29", 32'(editing), 1);
            end else begin
                check("to_edit30", 32'(editing), 0);
                check("to_cen30", 32'(count_en), 1);
                check("to_blink30", 32'(blink_hour), 0);
            end
            step(2);
        end
        check("to_noload", 32'(load_cnt - lc0), 0);

        // mode and inc edge together: mode wins
        cur_hour   = 5'd4;
        cur_minute = 6'd20;
        step(1);
        press_mode();
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        step(1);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step(1);
        commit_from_min(5'd4, 6'd20);
        step(2);

`ifdef CLOCK_ALARM_EN
        cur_hour   = 5'd12;
        cur_minute = 6'd0;
        step(1);
        press_mode();
        press_mode();
        press_mode();
        for (int i = 0; i < 7; i++) inc_once();
        press_mode();
        for (int i = 0; i < 30; i++) inc_once();
        begin
            ld_t e;
            e.h = 5'd12;
            e.m = 6'd0;
            e.s = 6'd0;
            sb.push_back(e);
            n_push++;
        end
        press_mode();
        step(2);
        cur_hour   = 5'd7;
        cur_minute = 6'd29;
        step(3);
        fc0 = fire_cnt;
        cur_minute = 6'd30;
        step(6);
        check("al_fire_once", 32'(fire_cnt - fc0), 1);
        cur_minute = 6'd29;
        step(3);
        press_mode();
        fc0 = fire_cnt;
        cur_minute = 6'd30;
        step(6);
        check("al_fire_edit", 32'(fire_cnt - fc0), 0);
        press_mode();
        commit_from_min(5'd7, 6'd29);
        step(2);
`else
        fc0 = fire_cnt;
        cur_hour   = 5'd0;
        cur_minute = 6'd1;
        step(2);
        cur_minute = 6'd0;
        step(3);
        check("al_tied_off", 32'(fire_cnt - fc0), 0);
`endif

        check("sb_empty", 32'(sb.size()), 0);
        check("load_total", 32'(load_cnt), 32'(n_push));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- Sequencing controller for the hour/minute/second timekeeping counter.
- Freezes the counter while the user edits hour and minute with two debounced buttons, then commits the new time through a one-cycle parallel load.
- Drives the display blink enables for the field being edited.
- Aborts the edit, without loading, after an idle timeout.

Parameters:
- TIMEOUT_S, 30: number of tick_1hz pulses with no button activity before the edit is abandoned.
- REPEAT_DLY, 8: clk cycles btn_inc must stay high after its rising edge before auto-repeat starts.
- REPEAT_PER, 4: clk cycles between auto-repeat increments while btn_inc stays held.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick_1hz  in  1  one-cycle pulse, 1 Hz
- btn_mode  in  1  one-cycle pulse from debouncer; advances the edit state
- btn_inc  in  1  debounced level; increments the selected field
- cur_hour  in  5  current hour from counter, 0..23
- cur_minute  in  6  current minute from counter, 0..59
- count_en  out  1  counter run enable
- load  out  1  one-cycle parallel-load strobe to counter
- load_hour  out  5  hour value to load
- load_minute  out  6  minute value to load
- load_second  out  6  second value to load (always 0)
- blink_hour  out  1  blank hour digits this cycle
- blink_minute  out  1  blank minute digits this cycle
- editing  out  1  high in any non-RUN state
- alarm_fire  out  1  alarm pulse (optional feature)

Behaviour:
- Reset values:
  - state = RUN, count_en = 1, load = 0, load_* = 0.
  - blink_* = 0, editing = 0, alarm_fire = 0.
  - shadow registers = 0, idle counter = 0, blink phase = 1.
- Reset applies mid-edit: return to RUN, no load issued.
- All outputs are registered.

State transitions:
- RUN:
  - count_en = 1.
  - btn_mode -> SET_HOUR; on the same edge, copy cur_hour and cur_minute into shadow_h and shadow_m.
- SET_HOUR: btn_mode -> SET_MIN. Increments apply to shadow_h, which wraps 23 -> 0.
- SET_MIN: btn_mode -> COMMIT. Increments apply to shadow_m, which wraps 59 -> 0.
- COMMIT:
  - Lasts exactly one cycle.
  - load = 1, load_hour = shadow_h, load_minute = shadow_m, load_second = 0.
  - count_en = 0.
  - Next state RUN, where count_en returns to 1.
- count_en = 0 in SET_HOUR, SET_MIN and COMMIT.

Increment and auto-repeat:
- A rising edge of btn_inc gives one increment on the following cycle.
- If btn_inc stays high for REPEAT_DLY cycles after the edge, one further increment follows every REPEAT_PER cycles until release.
- Release clears the repeat counter.
- btn_inc is ignored in RUN.

Simultaneous events:
- btn_mode together with an increment: btn_mode wins, the increment is dropped, and the repeat counter is cleared.

Timeout:
- The idle counter increments on tick_1hz while in SET_HOUR or SET_MIN.
- It clears on btn_mode, on a btn_inc edge, and while btn_inc is held.
- Reaching TIMEOUT_S -> RUN, with no load and shadows discarded.
- tick_1hz together with button activity: activity wins, and the counter clears.

Blink:
- The blink phase toggles on each tick_1hz.
- It is forced to 1 (digits shown) on any button activity.
- blink_hour = editing the hour field AND phase == 0.
- blink_minute = editing the minute field AND phase == 0.

Optional Feature:
CLOCK_ALARM_EN
- Defined:
  - Adds states SET_AL_HOUR and SET_AL_MIN between SET_MIN and COMMIT, so SET_MIN -> SET_AL_HOUR -> SET_AL_MIN -> COMMIT on successive btn_mode.
  - Alarm registers start at 00:00 after reset and are edited with the same increment and wrap rules.
  - Blink rules for these states match SET_HOUR and SET_MIN respectively.
  - COMMIT loads the time registers as normal; the alarm registers retain their edited values.
  - In RUN, alarm_fire pulses for one cycle on the first cycle that cur_hour:cur_minute equals the alarm after a change in cur_minute.
  - alarm_fire is suppressed while editing.
  - Timeout discards the alarm edits.
- Undefined: states are absent and alarm_fire is tied to 0.

Test Plan:
- Reset, then hold rst for 3 cycles during SET_MIN -> state RUN, count_en = 1, load never asserted, all outputs at reset values.
- cur = 23:59, then btn_mode, one btn_inc edge, btn_mode, one btn_inc edge, btn_mode -> single-cycle load with hour = 0, minute = 0, second = 0; count_en low from the first btn_mode until the load cycle, high after it.
- SET_MIN with shadow_m = 10, btn_inc held for REPEAT_DLY + 3*REPEAT_PER cycles (defaults 8, 4) -> shadow_m = 14 (1 edge increment + 3 repeats), then commit -> load_minute = 14.
- SET_HOUR, no buttons, 30 tick_1hz pulses -> back to RUN after the 30th tick, no load, blink_hour toggling while waiting, count_en = 1.
- SET_HOUR, btn_mode and btn_inc rising edge in the same cycle -> state SET_MIN, shadow_h unchanged.
- CLOCK_ALARM_EN: set alarm to 07:30 and commit; drive cur_minute from 29 to 30 with cur_hour = 7 -> alarm_fire high for exactly one cycle; repeat while editing -> no pulse.
